// File: rtl/miter_pkg.sv
// Shared types and constants for the ALU miter checking monitor.
// Holds the run FSM encoding and the miter control field layout.
package miter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Operation selector lives in control[3:2], operand mode in control[1:0].
   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      AMODE_PASS   = 2'd0,
      AMODE_CLRMSB = 2'd1,
      AMODE_CLRLSB = 2'd2,
      AMODE_AND    = 2'd3
   } amode_e;

   localparam logic [3:0] MATCH_CTRL_DEFAULT = {OP_MUL, AMODE_PASS};

   function automatic logic ctrl_matches(input logic [3:0] ctrl, input logic [3:0] match);
      return (ctrl == match);
   endfunction

endpackage

// File: rtl/miter_cex_capture.sv
// Counterexample register bank: latches one failing beat on cap, cleared by clr or rst.
module miter_cex_capture import miter_pkg::*; #(
   parameter int W     = 128,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             cap,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [3:0]       control,
   input  logic [CNT_W-1:0] index,
   output logic             cex_valid,
   output logic [W-1:0]     cex_a,
   output logic [W-1:0]     cex_b,
   output logic [3:0]       cex_control,
   output logic [CNT_W-1:0] cex_index
);

   logic             valid_d, valid_q;
   logic [W-1:0]     a_d, a_q, b_d, b_q;
   logic [3:0]       ctrl_d, ctrl_q;
   logic [CNT_W-1:0] idx_d, idx_q;

   // Next-state selection: clear has priority over capture.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      idx_d   = idx_q;
      if (clr) begin
         valid_d = 1'b0;
         a_d     = '0;
         b_d     = '0;
         ctrl_d  = 4'd0;
         idx_d   = '0;
      end else if (cap) begin
         valid_d = 1'b1;
         a_d     = a;
         b_d     = b;
         ctrl_d  = control;
         idx_d   = index;
      end else begin
         valid_d = valid_q;
      end
   end

   // Capture registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= 4'd0;
         idx_q   <= '0;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         idx_q   <= idx_d;
      end
   end

   assign cex_valid   = valid_q;
   assign cex_a       = a_q;
   assign cex_b       = b_q;
   assign cex_control = ctrl_q;
   assign cex_index   = idx_q;

endmodule

// File: rtl/miter_check_monitor.sv
// Consumes ALU miter beats, counts checked/skipped beats and stops on the first
// conditioned mismatch, keeping that beat as a counterexample.
module miter_check_monitor import miter_pkg::*; #(
   parameter int         W          = 128,
   parameter int         CNT_W      = 32,
   parameter logic [3:0] MATCH_CTRL = MATCH_CTRL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] budget,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W-1:0]     s_a,
   input  logic [W-1:0]     s_b,
   input  logic [3:0]       s_control,
   input  logic             s_result,
   input  logic             s_condition,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] total_cnt,
   output logic [CNT_W-1:0] checked_cnt,
   output logic             cond_err,
   output logic             cex_valid,
   output logic [W-1:0]     cex_a,
   output logic [W-1:0]     cex_b,
   output logic [3:0]       cex_control,
   output logic [CNT_W-1:0] cex_index
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] budget_d, budget_q;
   logic [CNT_W-1:0] total_d, total_q;
   logic [CNT_W-1:0] checked_d, checked_q;
   logic             cond_err_d, cond_err_q;
   logic             accept_s;
   logic             cap_s;
   logic             clr_s;

   // Ready depends only on registered state, never on s_valid.
   assign accept_s = s_valid && (state_q == ST_RUN);

   // Run FSM and counter next-state logic.
   always_comb begin
      state_d    = state_q;
      budget_d   = budget_q;
      total_d    = total_q;
      checked_d  = checked_q;
      cond_err_d = cond_err_q;
      cap_s      = 1'b0;
      clr_s      = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (accept_s) begin
               total_d = total_q + CNT_ONE;
               if (s_condition) begin
                  checked_d = checked_q + CNT_ONE;
               end else begin
                  checked_d = checked_q;
               end
               if (s_condition != ctrl_matches(s_control, MATCH_CTRL)) begin
                  cond_err_d = 1'b1;
               end else begin
                  cond_err_d = cond_err_q;
               end
               // A mismatch on the last budgeted beat still ends in FAIL.
               if (s_condition && s_result) begin
                  cap_s   = 1'b1;
                  state_d = ST_FAIL;
               end else if ((total_q + CNT_ONE) == budget_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_IDLE, ST_FAIL, ST_DONE: begin
            if (start) begin
               clr_s      = 1'b1;
               budget_d   = budget;
               total_d    = '0;
               checked_d  = '0;
               cond_err_d = 1'b0;
               if (budget == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         budget_q   <= '0;
         total_q    <= '0;
         checked_q  <= '0;
         cond_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         budget_q   <= budget_d;
         total_q    <= total_d;
         checked_q  <= checked_d;
         cond_err_q <= cond_err_d;
      end
   end

   miter_cex_capture #(
      .W     (W),
      .CNT_W (CNT_W)
   ) u_cex (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr_s),
      .cap         (cap_s),
      .a           (s_a),
      .b           (s_b),
      .control     (s_control),
      .index       (total_q),
      .cex_valid   (cex_valid),
      .cex_a       (cex_a),
      .cex_b       (cex_b),
      .cex_control (cex_control),
      .cex_index   (cex_index)
   );

   assign s_ready     = (state_q == ST_RUN);
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_FAIL) || (state_q == ST_DONE);
   assign pass        = (state_q == ST_DONE);
   assign total_cnt   = total_q;
   assign checked_cnt = checked_q;
   assign cond_err    = cond_err_q;

endmodule

// File: tb/tb_miter_check_monitor.sv
// Directed, table-driven bench for miter_check_monitor plus hand-written
// sequences for restart, start/budget latching and mid-run reset.
module tb_miter_check_monitor;

   localparam int W     = 128;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] budget = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [W-1:0]     s_a = '0;
   logic [W-1:0]     s_b = '0;
   logic [3:0]       s_control = 4'd0;
   logic             s_result = 1'b0;
   logic             s_condition = 1'b0;
   logic             busy, done, pass, cond_err, cex_valid;
   logic [CNT_W-1:0] total_cnt, checked_cnt, cex_index;
   logic [W-1:0]     cex_a, cex_b;
   logic [3:0]       cex_control;

   int checks = 0;
   int errors = 0;

   miter_check_monitor #(.W(W), .CNT_W(CNT_W), .MATCH_CTRL(4'b1000)) dut (
      .clk(clk), .rst(rst), .start(start), .budget(budget),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .s_control(s_control), .s_result(s_result), .s_condition(s_condition),
      .busy(busy), .done(done), .pass(pass), .total_cnt(total_cnt),
      .checked_cnt(checked_cnt), .cond_err(cond_err), .cex_valid(cex_valid),
      .cex_a(cex_a), .cex_b(cex_b), .cex_control(cex_control), .cex_index(cex_index)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  budget;
      logic [3:0]   ctrl;
      logic         cond;
      logic         res_all;
      int           fail_idx;
      logic         e_pass;
      logic [31:0]  e_total;
      logic [31:0]  e_checked;
      logic         e_cexv;
      logic [31:0]  e_idx;
      logic [127:0] e_a;
      logic [127:0] e_b;
      logic [3:0]   e_ctrl;
      logic         e_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      budget = b;
      @(negedge clk);
      start  = 1'b0;
      budget = 32'hFFFF_FFFF;
   endtask

   task automatic drive_beat(input int k, input logic [3:0] ctrl, input logic cond, input logic res);
      s_valid     = 1'b1;
      s_a         = 128'(2 * k + 1);
      s_b         = 128'(3 * k + 1);
      s_control   = ctrl;
      s_condition = cond;
      s_result    = res;
   endtask

   task automatic run_vec(input vec_t v, input int n);
      int  k;
      logic finished;
      k = 0;
      finished = 1'b0;
      do_start(v.budget);
      for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
         @(negedge clk);
         if (done) begin
            finished = 1'b1;
         end else begin
            drive_beat(k, v.ctrl, v.cond, v.res_all | (k == v.fail_idx));
            if (s_ready) k++;
         end
      end
      s_valid = 1'b0;
      chk($sformatf("v%0d_finished", n), finished, 1'b1);
      chk($sformatf("v%0d_done", n), done, 1'b1);
      chk($sformatf("v%0d_pass", n), pass, v.e_pass);
      chk($sformatf("v%0d_busy", n), busy, 1'b0);
      chk($sformatf("v%0d_s_ready", n), s_ready, 1'b0);
      chk($sformatf("v%0d_handshakes", n), 128'(k), 128'(v.e_total));
      chk($sformatf("v%0d_total", n), total_cnt, v.e_total);
      chk($sformatf("v%0d_checked", n), checked_cnt, v.e_checked);
      chk($sformatf("v%0d_cex_valid", n), cex_valid, v.e_cexv);
      chk($sformatf("v%0d_cex_index", n), cex_index, v.e_idx);
      chk($sformatf("v%0d_cex_a", n), cex_a, v.e_a);
      chk($sformatf("v%0d_cex_b", n), cex_b, v.e_b);
      chk($sformatf("v%0d_cex_control", n), cex_control, v.e_ctrl);
      chk($sformatf("v%0d_cond_err", n), cond_err, v.e_err);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_pass"}, pass, 1'b0);
      chk({tag, "_s_ready"}, s_ready, 1'b0);
      chk({tag, "_total"}, total_cnt, 32'd0);
      chk({tag, "_checked"}, checked_cnt, 32'd0);
      chk({tag, "_cond_err"}, cond_err, 1'b0);
      chk({tag, "_cex_valid"}, cex_valid, 1'b0);
      chk({tag, "_cex_a"}, cex_a, 128'd0);
      chk({tag, "_cex_b"}, cex_b, 128'd0);
      chk({tag, "_cex_control"}, cex_control, 4'd0);
      chk({tag, "_cex_index"}, cex_index, 32'd0);
   endtask

   initial begin
      //         budget ctrl     cond  res_all fail pass  total  checked cexv  idx    a        b        ctrl     err
      vecs[0] = '{32'd4, 4'b1000, 1'b1, 1'b0, -1, 1'b1, 32'd4, 32'd4, 1'b0, 32'd0, 128'd0, 128'd0, 4'b0000, 1'b0};
      vecs[1] = '{32'd8, 4'b1000, 1'b1, 1'b0,  2, 1'b0, 32'd3, 32'd3, 1'b1, 32'd2, 128'd5, 128'd7, 4'b1000, 1'b0};
      vecs[2] = '{32'd3, 4'b0000, 1'b0, 1'b1, -1, 1'b1, 32'd3, 32'd0, 1'b0, 32'd0, 128'd0, 128'd0, 4'b0000, 1'b0};
      vecs[3] = '{32'd2, 4'b0001, 1'b1, 1'b0, -1, 1'b1, 32'd2, 32'd2, 1'b0, 32'd0, 128'd0, 128'd0, 4'b0000, 1'b1};
      vecs[4] = '{32'd2, 4'b1000, 1'b1, 1'b0,  1, 1'b0, 32'd2, 32'd2, 1'b1, 32'd1, 128'd3, 128'd4, 4'b1000, 1'b0};
      vecs[5] = '{32'd5, 4'b0000, 1'b1, 1'b0,  0, 1'b0, 32'd1, 32'd1, 1'b1, 32'd0, 128'd1, 128'd1, 4'b0000, 1'b1};
      vecs[6] = '{32'd0, 4'b1000, 1'b1, 1'b0, -1, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 128'd0, 128'd0, 4'b0000, 1'b0};

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], i);
      end

      // Zero budget with s_valid held high: DONE at once, nothing accepted.
      @(negedge clk);
      s_valid = 1'b1;
      start   = 1'b1;
      budget  = 32'd0;
      @(negedge clk);
      start = 1'b0;
      chk("zb_done", done, 1'b1);
      chk("zb_pass", pass, 1'b1);
      chk("zb_ready", s_ready, 1'b0);
      @(negedge clk);
      chk("zb_total", total_cnt, 32'd0);
      s_valid = 1'b0;

      // FAIL holds its outputs while beats keep arriving.
      run_vec(vecs[1], 10);
      s_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("hold_total", total_cnt, 32'd3);
      chk("hold_done", done, 1'b0 | (pass == 1'b0));
      chk("hold_cex_index", cex_index, 32'd2);
      s_valid = 1'b0;

      // Restart after FAIL clears counters and counterexample.
      do_start(32'd3);
      chk("rs_busy", busy, 1'b1);
      chk("rs_ready", s_ready, 1'b1);
      chk("rs_total", total_cnt, 32'd0);
      chk("rs_cex_valid", cex_valid, 1'b0);
      chk("rs_cex_a", cex_a, 128'd0);

      // start and budget changes during RUN are ignored.
      @(negedge clk);
      drive_beat(0, 4'b1000, 1'b1, 1'b0);
      start  = 1'b1;
      budget = 32'd1;
      @(negedge clk);
      start = 1'b0;
      chk("lat_total1", total_cnt, 32'd1);
      chk("lat_busy", busy, 1'b1);
      drive_beat(1, 4'b1000, 1'b1, 1'b0);
      @(negedge clk);
      drive_beat(2, 4'b1000, 1'b1, 1'b0);
      @(negedge clk);
      chk("lat_pass", pass, 1'b1);
      chk("lat_total3", total_cnt, 32'd3);
      chk("lat_ready", s_ready, 1'b0);
      @(negedge clk);
      chk("lat_no_extra", total_cnt, 32'd3);
      s_valid = 1'b0;

      // Reset mid-RUN (with start and s_valid high) aborts everything.
      do_start(32'd5);
      @(negedge clk);
      drive_beat(0, 4'b0001, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_rst_total", total_cnt, 32'd1);
      chk("pre_rst_cond_err", cond_err, 1'b1);
      rst   = 1'b1;
      start = 1'b1;
      budget = 32'd7;
      @(negedge clk);
      chk_all_zero("midrst");
      rst   = 1'b0;
      start = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
